// File: rtl/uart_rx_cfg_if.sv
// Signal bundle between the UART receiver and its line / tick / register side.
interface uart_rx_cfg_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic            parity_en;
  logic            parity_odd;
  logic            two_stop;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            parity_err;
  logic            frame_err;
  logic            break_det;

  modport master (
    output rx, s_tick, parity_en, parity_odd, two_stop,
    input  rx_dout, rx_done_tick, parity_err, frame_err, break_det
  );

  modport slave (
    input  rx, s_tick, parity_en, parity_odd, two_stop,
    output rx_dout, rx_done_tick, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with 3-sample majority vote, run-time parity and
// stop-bit configuration, false-start rejection and framing/parity/break flags.
module uart_rx_cfg #(
  parameter int DBIT = 8,
  parameter int OVS  = 16
) (
  input logic          clk,
  input logic          reset_n,
  uart_rx_cfg_if.slave bus
);
  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBIT + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVS / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVS / 2 + 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_parity(input logic [DBIT-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t          state_r, state_s;
  logic            rx_meta_r, rxs_r;
  logic [SW-1:0]   s_r, s_s;
  logic [NW-1:0]   n_r, n_s;
  logic [DBIT-1:0] shreg_r, shreg_s;
  logic            v0_r, v0_s, v1_r, v1_s;
  logic            pen_r, pen_s, podd_r, podd_s, two_r, two_s;
  logic            perr_int_r, perr_int_s, pbit_r, pbit_s;
  logic [DBIT-1:0] dout_r, dout_s;
  logic            done_r, done_s, perr_r, perr_s, ferr_r, ferr_s, brk_r, brk_s;
  logic            in_bit_s, wrap_s, vote_now_s, vote_s;

  assign in_bit_s   = (state_r == START) || (state_r == DATA) ||
                      (state_r == PARITY) || (state_r == STOP);
  assign wrap_s     = in_bit_s && bus.s_tick && (s_r == S_LAST);
  assign vote_now_s = in_bit_s && bus.s_tick && (s_r == S_V2);
  assign vote_s     = maj3(v0_r, v1_r, rxs_r);

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // State register plus all datapath and registered output state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      s_r        <= {SW{1'b0}};
      n_r        <= {NW{1'b0}};
      shreg_r    <= {DBIT{1'b0}};
      v0_r       <= 1'b1;
      v1_r       <= 1'b1;
      pen_r      <= 1'b0;
      podd_r     <= 1'b0;
      two_r      <= 1'b0;
      perr_int_r <= 1'b0;
      pbit_r     <= 1'b0;
      dout_r     <= {DBIT{1'b0}};
      done_r     <= 1'b0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      brk_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      s_r        <= s_s;
      n_r        <= n_s;
      shreg_r    <= shreg_s;
      v0_r       <= v0_s;
      v1_r       <= v1_s;
      pen_r      <= pen_s;
      podd_r     <= podd_s;
      two_r      <= two_s;
      perr_int_r <= perr_int_s;
      pbit_r     <= pbit_s;
      dout_r     <= dout_s;
      done_r     <= done_s;
      perr_r     <= perr_s;
      ferr_r     <= ferr_s;
      brk_r      <= brk_s;
    end
  end

  // Next-state, bit-phase sampling and frame completion.
  always_comb begin
    state_s    = state_r;
    s_s        = s_r;
    n_s        = n_r;
    shreg_s    = shreg_r;
    v0_s       = v0_r;
    v1_s       = v1_r;
    pen_s      = pen_r;
    podd_s     = podd_r;
    two_s      = two_r;
    perr_int_s = perr_int_r;
    pbit_s     = pbit_r;
    dout_s     = dout_r;
    done_s     = 1'b0;
    perr_s     = perr_r;
    ferr_s     = ferr_r;
    brk_s      = brk_r;

    if (in_bit_s && bus.s_tick) begin
      s_s  = (s_r == S_LAST) ? {SW{1'b0}} : s_r + SW'(1);
      v0_s = (s_r == S_V0) ? rxs_r : v0_r;
      v1_s = (s_r == S_V1) ? rxs_r : v1_r;
    end else begin
      s_s = s_r;
    end

    case (state_r)
      IDLE: begin
        if (!rxs_r) begin
          state_s    = START;
          s_s        = {SW{1'b0}};
          pen_s      = bus.parity_en;
          podd_s     = bus.parity_odd;
          two_s      = bus.two_stop;
          perr_int_s = 1'b0;
          pbit_s     = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (vote_now_s && vote_s) begin
          state_s = IDLE;
        end else if (wrap_s) begin
          state_s = DATA;
          n_s     = {NW{1'b0}};
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (vote_now_s) begin
          shreg_s = {vote_s, shreg_r[DBIT-1:1]};
        end else begin
          shreg_s = shreg_r;
        end
        if (wrap_s) begin
          if (n_r == N_LAST) begin
            state_s = pen_r ? PARITY : STOP;
            n_s     = {NW{1'b0}};
          end else begin
            n_s = n_r + NW'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (vote_now_s) begin
          pbit_s     = vote_s;
          perr_int_s = (vote_s != exp_parity(shreg_r, podd_r));
        end else begin
          pbit_s = pbit_r;
        end
        state_s = wrap_s ? STOP : PARITY;
      end
      STOP: begin
        // A low stop bit ends the frame at once; break = everything low.
        if (vote_now_s) begin
          if (!vote_s) begin
            done_s  = 1'b1;
            dout_s  = shreg_r;
            perr_s  = pen_r & perr_int_r;
            ferr_s  = 1'b1;
            brk_s   = (shreg_r == {DBIT{1'b0}}) && (!pen_r || !pbit_r);
            state_s = WAIT_HIGH;
          end else if (!two_r || (n_r == NW'(1))) begin
            done_s  = 1'b1;
            dout_s  = shreg_r;
            perr_s  = pen_r & perr_int_r;
            ferr_s  = 1'b0;
            brk_s   = 1'b0;
            state_s = IDLE;
          end else begin
            n_s = NW'(1);
          end
        end else begin
          state_s = STOP;
        end
      end
      WAIT_HIGH: begin
        state_s = rxs_r ? IDLE : WAIT_HIGH;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.rx_dout      = dout_r;
  assign bus.rx_done_tick = done_r;
  assign bus.parity_err   = perr_r;
  assign bus.frame_err    = ferr_r;
  assign bus.break_det    = brk_r;
endmodule
